// File: rtl/sub_mean_pkg.sv
// Shared constants and arithmetic helpers for the audio front-end stages
// (mean subtraction, ZCR, STE).
package sub_mean_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int LOG2_WIN_DEF   = 4;
  localparam int SAT_W          = 64;

  // A running sum of 2**log2_win samples needs log2_win guard bits.
  function automatic int sum_width(input int data_width, input int log2_win);
    return data_width + log2_win;
  endfunction

  // Clamp a wide signed value into the signed out_w-bit range.
  // Callers take the low out_w bits. A result that differs from x means the value was clipped.
  function automatic logic signed [SAT_W-1:0] sat_signed(
    input logic signed [SAT_W-1:0] x,
    input int                      out_w
  );
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (out_w - 1));
    if (x > max_v) begin
      return max_v;
    end else if (x < min_v) begin
      return min_v;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/sub_mean_chan.sv
// One channel of the sliding-window DC remover: sample ring, running sum,
// centre-minus-mean subtract and saturation. Result is combinational; the top registers it.
module sub_mean_chan
  import sub_mean_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LOG2_WIN   = LOG2_WIN_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic                  flush,
  input  logic                  fill_full,
  input  logic                  bypass,
  input  logic [LOG2_WIN-1:0]   wr_ptr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_sat
);

  localparam int WIN = 1 << LOG2_WIN;
  localparam int SW  = sum_width(DATA_WIDTH, LOG2_WIN);

  logic [DATA_WIDTH-1:0] ring [WIN];
  logic signed [SW-1:0]  sum;
  logic signed [SW-1:0]  sum_next;
  logic signed [SW-1:0]  new_ext;
  logic signed [SW-1:0]  old_ext;
  logic [DATA_WIDTH-1:0] old_s;
  logic [DATA_WIDTH-1:0] centre;
  logic [DATA_WIDTH-1:0] mean;
  logic [LOG2_WIN-1:0]   ctr_ptr;
  logic [DATA_WIDTH:0]   diff;
  logic signed [SAT_W-1:0] diff_w;
  logic signed [SAT_W-1:0] sat_w;

  always_comb begin
    old_s    = fill_full ? ring[wr_ptr] : '0;
    new_ext  = {{LOG2_WIN{data_in[DATA_WIDTH-1]}}, data_in};
    old_ext  = {{LOG2_WIN{old_s[DATA_WIDTH-1]}}, old_s};
    sum_next = sum + new_ext - old_ext;
    // Dropping the low LOG2_WIN bits is an arithmetic shift: floor toward -inf.
    mean     = sum_next[SW-1:LOG2_WIN];
    // Centre is read before this frame's write; WIN/2 behind the write slot.
    ctr_ptr  = wr_ptr - LOG2_WIN'(WIN / 2);
    centre   = ring[ctr_ptr];
    diff     = {centre[DATA_WIDTH-1], centre} - {mean[DATA_WIDTH-1], mean};
    diff_w   = {{(SAT_W - DATA_WIDTH - 1){diff[DATA_WIDTH]}}, diff};
    sat_w    = sat_signed(diff_w, DATA_WIDTH);
    if (bypass) begin
      result     = centre;
      result_sat = 1'b0;
    end else begin
      result     = sat_w[DATA_WIDTH-1:0];
      result_sat = (sat_w != diff_w);
    end
  end

  // Ring contents are never reset; the fill counter hides stale entries.
  always_ff @(posedge clk) begin
    if (in_valid && !flush) begin
      ring[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum <= '0;
    end else if (flush) begin
      sum <= '0;
    end else if (in_valid) begin
      sum <= sum_next;
    end
  end

endmodule

// File: rtl/sub_mean_mc.sv
// Multi-channel sliding-window mean subtraction with bypass and flush.
// Owns the shared write pointer, fill counter and the output registers.
module sub_mean_mc
  import sub_mean_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LOG2_WIN   = LOG2_WIN_DEF,
  parameter int CHANNELS   = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           in_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
  input  logic                           bypass,
  input  logic                           flush,
  output logic [CHANNELS*DATA_WIDTH-1:0] subMean_out,
  output logic                           subMean_valid,
  output logic [CHANNELS-1:0]            sat
);

  // Handshake: in_valid qualifies data_in for exactly one frame, and there is
  // no ready; subMean_valid marks a one-cycle frame the consumer must take.

  localparam int WIN = 1 << LOG2_WIN;
  localparam logic [LOG2_WIN:0] FILL_MAX  = (LOG2_WIN + 1)'(WIN);
  localparam logic [LOG2_WIN:0] FILL_LAST = (LOG2_WIN + 1)'(WIN - 1);

  logic [LOG2_WIN-1:0]           wr_ptr;
  logic [LOG2_WIN:0]             fill;
  logic                          fill_full;
  logic                          frame_valid;
  logic [CHANNELS*DATA_WIDTH-1:0] res_bus;
  logic [CHANNELS-1:0]           res_sat;

  always_comb begin
    fill_full   = (fill == FILL_MAX);
    frame_valid = in_valid && !flush && (fill >= FILL_LAST);
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    sub_mean_chan #(
      .DATA_WIDTH (DATA_WIDTH),
      .LOG2_WIN   (LOG2_WIN)
    ) u_chan (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .flush      (flush),
      .fill_full  (fill_full),
      .bypass     (bypass),
      .wr_ptr     (wr_ptr),
      .data_in    (data_in[c*DATA_WIDTH +: DATA_WIDTH]),
      .result     (res_bus[c*DATA_WIDTH +: DATA_WIDTH]),
      .result_sat (res_sat[c])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr        <= '0;
      fill          <= '0;
      subMean_out   <= '0;
      subMean_valid <= 1'b0;
      sat           <= '0;
    end else begin
      subMean_valid <= frame_valid;
      if (flush) begin
        wr_ptr <= '0;
        fill   <= '0;
      end else if (in_valid) begin
        wr_ptr <= wr_ptr + LOG2_WIN'(1);
        if (!fill_full) begin
          fill <= fill + (LOG2_WIN + 1)'(1);
        end
      end
      // Outputs only move on frames that carry a full window.
      if (frame_valid) begin
        subMean_out <= res_bus;
        sat         <= res_sat;
      end
    end
  end

endmodule

// File: tb/tb_sub_mean_mc.sv
// Self-checking bench for sub_mean_mc with defaults (16-bit, WIN 16, 2 channels).
// A history-queue reference model predicts each output frame.
module tb_sub_mean_mc;

  localparam int DW  = 16;
  localparam int LW  = 4;
  localparam int CH  = 2;
  localparam int WIN = 1 << LW;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           bypass = 1'b0;
  logic           flush = 1'b0;
  logic [CH*DW-1:0] data_in = '0;
  logic [CH*DW-1:0] subMean_out;
  logic           subMean_valid;
  logic [CH-1:0]  sat;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  sub_mean_mc #(.DATA_WIDTH(DW), .LOG2_WIN(LW), .CHANNELS(CH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .data_in       (data_in),
    .bypass        (bypass),
    .flush         (flush),
    .subMean_out   (subMean_out),
    .subMean_valid (subMean_valid),
    .sat           (sat)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic [CH*DW+CH-1:0] exp_q[$];
  int  h0[$];
  int  h1[$];
  int  n_acc = 0;
  logic [CH*DW-1:0] last_out = '0;
  logic [CH-1:0]    last_sat = '0;
  bit  known = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int s16(input int x);
    logic [15:0] t;
    t = 16'(x);
    return int'($signed(t));
  endfunction

  function automatic int floor_mean(input int s);
    if (s >= 0) return s / WIN;
    return -((-s + WIN - 1) / WIN);
  endfunction

  // Expected {sat, value} for one channel from its last WIN accepted samples.
  function automatic logic [16:0] chan_exp(input int h[$], input bit byp);
    int s;
    int centre;
    int d;
    s = 0;
    for (int k = 0; k < WIN; k++) s += h[k];
    centre = h[WIN - 1 - WIN / 2];
    if (byp) return {1'b0, 16'(centre)};
    d = centre - floor_mean(s);
    if (d > 32767)  return {1'b1, 16'h7fff};
    if (d < -32768) return {1'b1, 16'h8000};
    return {1'b0, 16'(d)};
  endfunction

  task automatic model_clear();
    h0.delete();
    h1.delete();
    n_acc = 0;
  endtask

  task automatic model_push(input int d0, input int d1, input bit byp, output bit exp_v);
    logic [16:0] e0;
    logic [16:0] e1;
    h0.push_back(s16(d0));
    h1.push_back(s16(d1));
    if (h0.size() > WIN) begin
      void'(h0.pop_front());
      void'(h1.pop_front());
    end
    n_acc++;
    exp_v = 1'b0;
    if (n_acc >= WIN) begin
      e0 = chan_exp(h0, byp);
      e1 = chan_exp(h1, byp);
      exp_q.push_back({e1[16], e0[16], e1[15:0], e0[15:0]});
      exp_v = 1'b1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit v, input int d0, input int d1, input bit byp, input bit fl);
    bit exp_v;
    logic [CH*DW+CH-1:0] w;
    @(negedge clk);
    in_valid = v;
    flush    = fl;
    bypass   = byp;
    data_in  = {16'(d1), 16'(d0)};
    exp_v    = 1'b0;
    if (fl) model_clear();
    else if (v) model_push(d0, d1, byp, exp_v);
    @(posedge clk);
    #1;
    check("valid", 64'(subMean_valid), 64'(exp_v));
    if (exp_v) begin
      w = exp_q.pop_front();
      check("out", 64'(subMean_out), 64'(w[CH*DW-1:0]));
      check("sat", 64'(sat), 64'(w[CH*DW+CH-1:CH*DW]));
      last_out = w[CH*DW-1:0];
      last_sat = w[CH*DW+CH-1:CH*DW];
      known    = 1'b1;
    end else if (v && !fl) begin
      known = 1'b0;
    end else if (!v && !fl && known) begin
      check("hold_out", 64'(subMean_out), 64'(last_out));
      check("hold_sat", 64'(sat), 64'(last_sat));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_out", 64'(subMean_out), 64'd0);
    check("rst_valid", 64'(subMean_valid), 64'd0);
    check("rst_sat", 64'(sat), 64'd0);
    model_clear();
    last_out = '0;
    last_sat = '0;
    known    = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic do_flush();
    step(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int r0;
    int r1;
    int k;
    // Power-on reset
    repeat (2) @(negedge clk);
    check("por_out", 64'(subMean_out), 64'd0);
    check("por_valid", 64'(subMean_valid), 64'd0);
    check("por_sat", 64'(sat), 64'd0);
    reset_n = 1'b1;

    // Constant input: mean removal gives zero once the window fills
    for (int i = 0; i < 20; i++) step(1'b1, 1000, 1000, 1'b0, 1'b0);

    // Alternating +/-100 on ch0, ramp on ch1
    do_flush();
    for (int i = 0; i < 20; i++) step(1'b1, (i % 2 == 0) ? 100 : -100, i, 1'b0, 1'b0);

    // Negative saturation: centre -32768 against mean 28671
    do_flush();
    for (int i = 0; i < 16; i++) step(1'b1, (i == 7) ? -32768 : 32767, (i == 7) ? -32768 : 32767, 1'b0, 1'b0);

    // Same stream in bypass mode
    do_flush();
    for (int i = 0; i < 16; i++) step(1'b1, (i == 7) ? -32768 : 32767, (i == 7) ? -32768 : 32767, 1'b1, 1'b0);

    // Positive saturation: centre 32767 against a deeply negative mean
    do_flush();
    for (int i = 0; i < 16; i++) step(1'b1, (i == 7) ? 32767 : -32768, 0, 1'b0, 1'b0);

    // Gapped random stream, one valid every third cycle
    do_flush();
    for (int i = 0; i < 66; i++) begin
      r0 = int'($urandom_range(0, 65535));
      r1 = int'($urandom_range(0, 65535));
      step(i % 3 == 0, r0, r1, 1'b0, 1'b0);
    end

    // Flush mid-stream at frame 20 (that frame is discarded)
    for (int i = 0; i < 40; i++) begin
      r0 = int'($urandom_range(0, 65535));
      r1 = int'($urandom_range(0, 65535));
      step(1'b1, r0, r1, 1'b0, i == 20);
    end

    // Asynchronous reset mid-stream at frame 20
    for (int i = 0; i < 40; i++) begin
      if (i == 20) do_reset();
      r0 = int'($urandom_range(0, 65535));
      r1 = int'($urandom_range(0, 65535));
      step(1'b1, r0, r1, 1'b0, 1'b0);
    end

    // Random valid, data and bypass; moderate amplitude on ch1
    for (int i = 0; i < 120; i++) begin
      r0 = int'($urandom_range(0, 65535));
      r1 = int'($urandom_range(0, 8000)) - 4000;
      k  = int'($urandom_range(0, 3));
      step(k != 0, r0, r1, $urandom_range(0, 1) == 1, 1'b0);
    end

    step(1'b0, 0, 0, 1'b0, 1'b0);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
